// File: rtl/tx_frame_builder.sv
// GMII TX frame builder: preamble, MAC header, segment header, VRAM payload and FCS,
// followed by the inter-frame gap. byte_data_counter paces the upstream memory reads.
module tx_frame_builder #(
    parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC   = 48'h00_0A_35_01_02_03,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          PAYLOAD   = 1437,
    parameter int          IFG       = 12
) (
    input  logic        clk125MHz,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  txid,
    input  logic [7:0]  redundancy,
    input  logic [15:0] segment_num,
    input  logic [15:0] segment_num_max,
    input  logic [15:0] startaddr,
    input  logic [7:0]  payload_byte,
    output logic [11:0] byte_data_counter,
    output logic        data_user,
    output logic        busy,
    output logic        frame_done,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd
);

    localparam int PAY_FIRST_I = 46;
    localparam int PAY_LAST_I  = PAY_FIRST_I + PAYLOAD - 1;
    localparam int FCS_FIRST_I = PAY_LAST_I + 1;
    localparam int FCS_LAST_I  = FCS_FIRST_I + 3;

    localparam logic [11:0] CRC_FIRST  = 12'd8;
    localparam logic [11:0] PAY_FIRST  = 12'(PAY_FIRST_I);
    localparam logic [11:0] PAY_LAST   = 12'(PAY_LAST_I);
    localparam logic [11:0] FRAME_LAST = 12'(FCS_LAST_I);
    localparam logic [11:0] GAP_LAST   = 12'(FCS_LAST_I + IFG);

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t      state_q;
    logic [11:0] cnt_q;
    logic        busy_q, data_user_q, frame_done_q, tx_en_q;
    logic [7:0]  txd_q;
    logic [31:0] crc_q;
    logic [7:0]  txid_q, redundancy_q, sa_lo_q;
    logic [15:0] seg_q, seg_max_q;

    logic [7:0]  byte_d;
    logic [11:0] cnt_d;
    logic [31:0] fcs;
    int          idx;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        // NOTE: blocking assignments are right here: this is pure combinational math on a local.
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    assign cnt_d = cnt_q + 12'd1;

    // NOTE: every variable gets a default before the decode, so no latch can be inferred.
    always_comb begin
        byte_d = 8'h00;
        fcs    = ~crc_q;
        idx    = int'(cnt_q);
        if (idx <= 6)                byte_d = 8'h55;
        else if (idx == 7)           byte_d = 8'hD5;
        else if (idx <= 13)          byte_d = DST_MAC[8*(13-idx) +: 8];
        else if (idx <= 19)          byte_d = SRC_MAC[8*(19-idx) +: 8];
        else if (idx == 20)          byte_d = ETHERTYPE[15:8];
        else if (idx == 21)          byte_d = ETHERTYPE[7:0];
        else if (idx == 22)          byte_d = txid_q;
        else if (idx == 23)          byte_d = redundancy_q;
        else if (idx == 24)          byte_d = seg_q[15:8];
        else if (idx == 25)          byte_d = seg_q[7:0];
        else if (idx == 26)          byte_d = seg_max_q[15:8];
        else if (idx == 27)          byte_d = seg_max_q[7:0];
        else if (idx <= 39)          byte_d = 8'h00;
        else if (idx == 40)          byte_d = startaddr[15:8];
        else if (idx == 41)          byte_d = sa_lo_q;
        else if (idx < PAY_FIRST_I)  byte_d = 8'h00;
        else if (idx <= PAY_LAST_I)  byte_d = payload_byte;
        else if (idx <= FCS_LAST_I)  byte_d = fcs[8*(idx-FCS_FIRST_I) +: 8];
    end

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            data_user_q  <= 1'b0;
            frame_done_q <= 1'b0;
            tx_en_q      <= 1'b0;
            txd_q        <= '0;
            crc_q        <= '1;
            txid_q       <= '0;
            redundancy_q <= '0;
            seg_q        <= '0;
            seg_max_q    <= '0;
            sa_lo_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (cnt_q == 12'd0)
                crc_q <= '1;
            unique case (state_q)
                IDLE: begin
                    tx_en_q <= 1'b0;
                    txd_q   <= '0;
                    if (start) begin
                        txid_q       <= txid;
                        redundancy_q <= redundancy;
                        seg_q        <= segment_num;
                        seg_max_q    <= segment_num_max;
                        busy_q       <= 1'b1;
                        state_q      <= FRAME;
                    end
                end
                FRAME: begin
                    tx_en_q     <= 1'b1;
                    txd_q       <= byte_d;
                    cnt_q       <= cnt_d;
                    data_user_q <= (cnt_d >= PAY_FIRST) && (cnt_d <= PAY_LAST);
                    if (cnt_q >= CRC_FIRST && cnt_q <= PAY_LAST)
                        crc_q <= crc32_byte(crc_q, byte_d);
                    // Memory control moves startaddr again after n==40; keep the low byte for n==41.
                    if (cnt_q == 12'd40)
                        sa_lo_q <= startaddr[7:0];
                    if (cnt_q == FRAME_LAST)
                        state_q <= GAP;
                end
                GAP: begin
                    tx_en_q <= 1'b0;
                    txd_q   <= '0;
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q        <= cnt_d;
                        frame_done_q <= (cnt_d == GAP_LAST);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_data_counter = cnt_q;
    assign data_user         = data_user_q;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;
    assign gmii_tx_en        = tx_en_q;
    assign gmii_txd          = txd_q;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Randomized bench for tx_frame_builder: a cycle model tracks frame position, a scoreboard
// queue holds expected GMII bytes built from the byte map, and a monitor compares every cycle.
module tb_tx_frame_builder;

    localparam int FLEN = 1487;
    localparam int PLEN = 1437;
    localparam int LAST = 1498;

    logic        clk125MHz = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  txid = '0, redundancy = '0, payload_byte = '0;
    logic [15:0] segment_num = '0, segment_num_max = '0, startaddr = '0;
    logic [11:0] byte_data_counter;
    logic        data_user, busy, frame_done, gmii_tx_en;
    logic [7:0]  gmii_txd;

    tx_frame_builder dut (
        .clk125MHz        (clk125MHz),
        .rst              (rst),
        .start            (start),
        .txid             (txid),
        .redundancy       (redundancy),
        .segment_num      (segment_num),
        .segment_num_max  (segment_num_max),
        .startaddr        (startaddr),
        .payload_byte     (payload_byte),
        .byte_data_counter(byte_data_counter),
        .data_user        (data_user),
        .busy             (busy),
        .frame_done       (frame_done),
        .gmii_tx_en       (gmii_tx_en),
        .gmii_txd         (gmii_txd)
    );

    always #4 clk125MHz = ~clk125MHz;

    int          checks = 0;
    int          failures = 0;
    int          s = -1;
    bit          aborted = 1'b0;
    int          frames_exp = 0;
    int          frames_seen = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx[$];
    bit          prev_en = 1'b0;
    logic [7:0]  pay[PLEN];
    logic [15:0] cur_sa = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-serial reflected CRC-32 register over d[lo..hi], no final inversion.
    function automatic logic [31:0] crc_reg(input logic [7:0] d[$], input int lo, input int hi);
        logic [31:0] crc = 32'hFFFF_FFFF;
        for (int i = lo; i <= hi; i++)
            for (int b = 0; b < 8; b++) begin
                logic fb = crc[0] ^ d[i][b];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB8_8320;
            end
        return crc;
    endfunction

    function automatic void push_frame();
        logic [7:0]  f[$];
        logic [47:0] dst = 48'hFF_FF_FF_FF_FF_FF;
        logic [47:0] src = 48'h00_0A_35_01_02_03;
        logic [31:0] fcs;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) f.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(src[8*i +: 8]);
        f.push_back(8'h88); f.push_back(8'hB5);
        f.push_back(txid); f.push_back(redundancy);
        f.push_back(segment_num[15:8]); f.push_back(segment_num[7:0]);
        f.push_back(segment_num_max[15:8]); f.push_back(segment_num_max[7:0]);
        for (int i = 0; i < 12; i++) f.push_back(8'h00);
        f.push_back(cur_sa[15:8]); f.push_back(cur_sa[7:0]);
        for (int i = 0; i < 4; i++) f.push_back(8'h00);
        for (int i = 0; i < PLEN; i++) f.push_back(pay[i]);
        fcs = ~crc_reg(f, 8, f.size() - 1);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        foreach (f[i]) exp_q.push_back(f[i]);
    endfunction

    // Cycle model: s is the frame position (-1 = idle), stepped on the same edge as the DUT.
    always @(posedge clk125MHz) begin
        if (rst) begin
            if (s >= 0) begin
                aborted = 1'b1;
                frames_exp--;
            end
            s = -1;
            exp_q.delete();
        end else if (s < 0) begin
            if (start) begin
                s = 0;
                push_frame();
                frames_exp++;
            end
        end else begin
            s = (s == LAST) ? -1 : s + 1;
        end
    end

    // Upstream emulation: payload follows frame position, startaddr valid only for n=37..40.
    always @(posedge clk125MHz) begin
        #1;
        if (s >= 46 && s <= 46 + PLEN - 1) payload_byte = pay[s-46];
        else                                payload_byte = 8'($urandom);
        if (s >= 37 && s <= 40) startaddr = cur_sa;
        else                    startaddr = 16'($urandom);
        if (s >= 1) begin
            txid            = 8'($urandom);
            redundancy      = 8'($urandom);
            segment_num     = 16'($urandom);
            segment_num_max = 16'($urandom);
        end
    end

    // Monitor: control outputs every cycle, bytes popped from the scoreboard while tx_en is high.
    always @(negedge clk125MHz) begin
        logic [15:0] exp_ctrl;
        logic [11:0] ec;
        ec = (s < 0) ? 12'd0 : 12'(s);
        exp_ctrl = {ec, s >= 0, s >= 46 && s <= 1482, s == LAST, s >= 1 && s <= FLEN};
        check("ctrl{cnt,busy,user,done,en}",
              {16'h0, byte_data_counter, busy, data_user, frame_done, gmii_tx_en}, {16'h0, exp_ctrl});
        if (gmii_tx_en) begin
            rx.push_back(gmii_txd);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_byte: got 0x%0h, expected no byte (t=%0t)", gmii_txd, $time);
            end else begin
                check($sformatf("txd[%0d]", rx.size() - 1), {24'h0, gmii_txd}, {24'h0, exp_q.pop_front()});
            end
        end
        if (prev_en && !gmii_tx_en) begin
            if (aborted) begin
                aborted = 1'b0;
            end else begin
                check("frame_len", rx.size(), FLEN);
                if (rx.size() > 12)
                    check("fcs_residue", crc_reg(rx, 8, rx.size() - 1), 32'hDEBB_20E3);
            end
            rx.delete();
        end
        if (frame_done) frames_seen++;
        prev_en = gmii_tx_en;
    end

    task automatic tick();
        @(posedge clk125MHz);
        #1;
    endtask

    task automatic wait_s(input int target);
        int n = 0;
        while (s != target && n < 3000) begin
            tick();
            n++;
        end
        if (s != target) begin
            checks++;
            failures++;
            $display("FAIL wait_s: position %0d, expected %0d within 3000 cycles", s, target);
        end
    endtask

    task automatic send(input logic [7:0] id, input logic [15:0] seg, input logic [15:0] sa);
        txid            = id;
        redundancy      = 8'($urandom);
        segment_num     = seg;
        segment_num_max = 16'($urandom);
        cur_sa          = sa;
        start           = 1'b1;
        tick();
        start           = 1'b0;
    endtask

    task automatic rand_payload();
        foreach (pay[i]) pay[i] = 8'($urandom);
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #(8 * 40000);
        failures++;
        $display("FAIL watchdog: simulation exceeded 40000 cycles");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        rand_payload();
        repeat (3) tick();
        check("rst_txd",     {24'h0, gmii_txd}, 32'h0);
        check("rst_tx_en",   {31'h0, gmii_tx_en}, 32'h0);
        check("rst_counter", {20'h0, byte_data_counter}, 32'h0);
        check("rst_busy",    {31'h0, busy}, 32'h0);
        check("rst_user",    {31'h0, data_user}, 32'h0);
        check("rst_done",    {31'h0, frame_done}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic frame: txid=1, segment 5.
        send(8'd1, 16'd5, 16'($urandom));
        wait_s(-1);

        // Header fields: segment 0x0102, startaddr 0xABCD.
        rand_payload();
        send(8'd2, 16'h0102, 16'hABCD);
        wait_s(-1);

        // Payload ramp.
        foreach (pay[i]) pay[i] = 8'((46 + i) & 8'hFF);
        send(8'd3, 16'($urandom), 16'($urandom));
        wait_s(-1);

        // Starts while busy are dropped; the cycle after frame_done accepts.
        rand_payload();
        send(8'($urandom), 16'($urandom), 16'($urandom));
        wait_s(500);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_s(LAST);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_s(-1);

        // Mid-frame reset aborts without frame_done, then a clean frame follows.
        rand_payload();
        send(8'($urandom), 16'($urandom), 16'($urandom));
        wait_s(800);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_tx_en",   {31'h0, gmii_tx_en}, 32'h0);
        check("abort_counter", {20'h0, byte_data_counter}, 32'h0);
        check("abort_busy",    {31'h0, busy}, 32'h0);
        tick();
        rand_payload();
        send(8'($urandom), 16'($urandom), 16'($urandom));
        wait_s(-1);

        // Random back-to-back frames with short random gaps.
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 5)) tick();
            rand_payload();
            send(8'($urandom), 16'($urandom), 16'($urandom));
            wait_s(-1);
        end

        repeat (5) tick();
        check("frames_done", frames_seen, frames_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        summary();
        $finish;
    end

endmodule
